// File: rtl/vxe_vpu_actf_eu_if.sv
// Activation-function execution unit bus.
// Groups the ECU start/busy handshake, the latched operation controls and
// the register-file read/write ports of the activation EU.
//   i_start/o_busy       : one-cycle start pulse in, operation-in-progress out
//   i_leaky/i_expd       : mode (1 = leaky ReLU) and leaky slope exponent
//   o_rf_rd_*/i_rf_rd_*  : register-file read port (data one cycle after strobe)
//   o_rf_wr_*            : register-file write port
// Modport slave is the execution unit; modport master is the ECU/RF side.
interface vxe_vpu_actf_eu_if #(
  parameter int IDXW = 3
);
  logic            i_start;
  logic            o_busy;
  logic            i_leaky;
  logic [6:0]      i_expd;
  logic            o_rf_rd_en;
  logic [IDXW-1:0] o_rf_rd_idx;
  logic [31:0]     i_rf_rd_data;
  logic            o_rf_wr_en;
  logic [IDXW-1:0] o_rf_wr_idx;
  logic [31:0]     o_rf_wr_data;

  modport slave (
    input  i_start, i_leaky, i_expd, i_rf_rd_data,
    output o_busy, o_rf_rd_en, o_rf_rd_idx, o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data
  );

  modport master (
    output i_start, i_leaky, i_expd, i_rf_rd_data,
    input  o_busy, o_rf_rd_en, o_rf_rd_idx, o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data
  );
endinterface

// File: rtl/vxe_vpu_actf_eu.sv
// Activation-function execution unit of the VxE VPU.
// On a start pulse it streams every FP32 element of a vector register
// through ReLU or leaky ReLU (slope 2^-expd) and writes each result back to
// the same index. Reads issue one per cycle; each write lands two cycles
// after the read of the same element. o_busy covers the whole operation.
// Ports:
//   clk  : clock, rising edge
//   nrst : asynchronous active-low reset (clears all outputs and pipeline)
//   bus  : vxe_vpu_actf_eu_if.slave (handshake, mode, RF read/write ports)
module vxe_vpu_actf_eu #(
  parameter int VLEN   = 8,
  parameter int IDXW   = 3,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               nrst,
  vxe_vpu_actf_eu_if.slave   bus
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VLEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                leaky_q, leaky_d;
  logic [6:0]          expd_q, expd_d;
  logic                rd_en_q, rd_en_d;
  logic [IDXW-1:0]     rd_idx_q, rd_idx_d;
  logic                vld_p1_q, vld_p1_d;
  logic [IDXW-1:0]     idx_p1_q, idx_p1_d;
  logic                wr_en_q, wr_en_d;
  logic [IDXW-1:0]     wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  // ReLU / leaky ReLU on raw FP32 fields. Leaky scaling is an exponent
  // subtraction; anything that would underflow flushes to -0.
  function automatic logic [DATA_W-1:0] act_fn(input logic [DATA_W-1:0] x,
                                               input logic              leaky,
                                               input logic [6:0]        expd);
    logic [7:0] e;
    logic [7:0] ex8;
    e      = x[30:23];
    ex8    = {1'b0, expd};
    act_fn = x;
    if (x[31]) begin
      if (!leaky)
        act_fn = '0;
      else if (e == 8'hFF)
        act_fn = x;
      else if (e <= ex8)           // also catches zero/denormal (e == 0)
        act_fn = 32'h8000_0000;
      else
        act_fn = {1'b1, e - ex8, x[22:0]};
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    leaky_d   = leaky_q;
    expd_d    = expd_q;
    rd_en_d   = rd_en_q;
    rd_idx_d  = rd_idx_q;
    // p1: read strobe/index delayed to line up with returning read data
    vld_p1_d  = rd_en_q;
    idx_p1_d  = rd_idx_q;
    // p2: activation result registered onto the write port
    wr_en_d   = vld_p1_q;
    wr_idx_d  = idx_p1_q;
    wr_data_d = vld_p1_q ? act_fn(bus.i_rf_rd_data, leaky_q, expd_q) : wr_data_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          leaky_d  = bus.i_leaky;
          expd_d   = bus.i_expd;
          rd_en_d  = 1'b1;
          rd_idx_d = '0;
        end
      end
      RUN: begin
        if (rd_idx_q == LAST_IDX) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_en_d  = 1'b1;
          rd_idx_d = rd_idx_q + IDXW'(1);
        end
      end
      DRAIN: begin
        if (wr_en_q && (wr_idx_q == LAST_IDX)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      leaky_q   <= 1'b0;
      expd_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_idx_q  <= '0;
      vld_p1_q  <= 1'b0;
      idx_p1_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      leaky_q   <= leaky_d;
      expd_q    <= expd_d;
      rd_en_q   <= rd_en_d;
      rd_idx_q  <= rd_idx_d;
      vld_p1_q  <= vld_p1_d;
      idx_p1_q  <= idx_p1_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_rf_rd_en   = rd_en_q;
  assign bus.o_rf_rd_idx  = rd_idx_q;
  assign bus.o_rf_wr_en   = wr_en_q;
  assign bus.o_rf_wr_idx  = wr_idx_q;
  assign bus.o_rf_wr_data = wr_data_q;

endmodule

// File: tb/tb_vxe_vpu_actf_eu.sv
// Testbench for vxe_vpu_actf_eu: register-file model, scoreboard queues
// filled at start, and a negedge monitor that pops on every read/write.
module tb_vxe_vpu_actf_eu;
  localparam int VLEN = 8;
  localparam int IDXW = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  vxe_vpu_actf_eu_if #(.IDXW(IDXW)) bus ();

  vxe_vpu_actf_eu #(.VLEN(VLEN), .IDXW(IDXW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rf    [VLEN];
  logic [31:0] exp_v [VLEN];
  int          riq[$];
  int          wiq[$];
  logic [31:0] wq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: ReLU / leaky ReLU (x * 2^-expd) on FP32 fields.
  function automatic logic [31:0] ref_act(input logic [31:0] x, input logic lk, input logic [6:0] ex);
    int e;
    e = int'(x[30:23]);
    if (!x[31]) return x;
    if (!lk) return 32'h0000_0000;
    if (e == 255) return x;
    if (e <= int'(ex)) return 32'h8000_0000;
    return {1'b1, 8'(e - int'(ex)), x[22:0]};
  endfunction

  function automatic logic [31:0] rand_elem(input logic [6:0] ex);
    logic [7:0] e;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = {1'b0, ex};
      3:       e = {1'b0, ex} + 8'd1;
      default: e = 8'($urandom_range(0, 255));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic gen_random(input logic lk, input logic [6:0] ex);
    for (int i = 0; i < VLEN; i++) begin
      rf[i]    = rand_elem(ex);
      exp_v[i] = ref_act(rf[i], lk, ex);
    end
  endtask

  // Register file read port: data one cycle after the strobe.
  always @(posedge clk)
    if (bus.o_rf_rd_en) bus.i_rf_rd_data <= rf[bus.o_rf_rd_idx];

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.o_rf_rd_en) begin
        check("rd_pending", 64'(riq.size() != 0), 64'(1));
        if (riq.size() != 0) check("rd_idx", 64'(bus.o_rf_rd_idx), 64'(riq.pop_front()));
      end
      if (bus.o_rf_wr_en) begin
        check("wr_pending", 64'(wq.size() != 0), 64'(1));
        if (wq.size() != 0) begin
          check("wr_idx", 64'(bus.o_rf_wr_idx), 64'(wiq.pop_front()));
          check("wr_data", 64'(bus.o_rf_wr_data), 64'(wq.pop_front()));
        end
      end
      check("idle_strobes", 64'({bus.o_rf_rd_en, bus.o_rf_wr_en} & {2{~bus.o_busy}}), 64'(0));
    end
  end

  // Called at a negedge; start is presented in the current cycle (cycle 0).
  task automatic run_op(input logic lk, input logic [6:0] ex, input int glitch,
                        input int chg, input int abort);
    int cyc, busy_cnt, wr_cnt, first_wr;
    for (int i = 0; i < VLEN; i++) begin
      riq.push_back(i);
      wiq.push_back(i);
      wq.push_back(exp_v[i]);
    end
    bus.i_start = 1'b1;
    bus.i_leaky = lk;
    bus.i_expd  = ex;
    cyc = 0; busy_cnt = 0; wr_cnt = 0; first_wr = -1;
    while (1) begin
      @(negedge clk);
      cyc++;
      bus.i_start = (cyc == glitch);
      if (cyc == chg) begin
        bus.i_leaky = ~lk;
        bus.i_expd  = ex + 7'd9;
      end
      if (cyc == 1) check("first_read", 64'({bus.o_rf_rd_en, bus.o_busy, bus.o_rf_rd_idx}), 64'({2'b11, 3'd0}));
      if (cyc == abort) begin
        #2 nrst = 1'b0;
        #1 check("reset_async_outputs",
                 64'({bus.o_busy, bus.o_rf_rd_en, bus.o_rf_rd_idx, bus.o_rf_wr_en,
                      bus.o_rf_wr_idx, bus.o_rf_wr_data}), 64'(0));
        riq.delete(); wiq.delete(); wq.delete();
        break;
      end
      if (bus.o_rf_wr_en) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
      end
      if (!bus.o_busy) break;
      busy_cnt++;
      if (cyc > 4 * VLEN) break;
    end
    if (abort == 0) begin
      check("busy_cycles", 64'(busy_cnt), 64'(VLEN + 2));
      check("first_write_cycle", 64'(first_wr), 64'(3));
      check("write_count", 64'(wr_cnt), 64'(VLEN));
      check("queues_drained", 64'(wq.size() + riq.size()), 64'(0));
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_leaky = 1'b0;
    bus.i_expd  = '0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({bus.o_busy, bus.o_rf_rd_en, bus.o_rf_rd_idx, bus.o_rf_wr_en,
               bus.o_rf_wr_idx, bus.o_rf_wr_data}), 64'(0));
    nrst = 1'b1;
    @(negedge clk);

    // ReLU specials
    rf    = '{32'h40000000, 32'hBF800000, 32'h00000000, 32'h80000000,
              32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFFC00000};
    exp_v = '{32'h40000000, 32'h00000000, 32'h00000000, 32'h00000000,
              32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h00000000};
    run_op(1'b0, 7'd0, 0, 0, 0);

    // Leaky expd=3 (back-to-back start in first idle cycle)
    rf    = '{32'hBF800000, 32'hC0000000, 32'h3F800000, 32'hFFC00000,
              32'h80000001, 32'h00000000, 32'hC1200000, 32'h80000000};
    exp_v = '{32'hBE000000, 32'hBE800000, 32'h3F800000, 32'hFFC00000,
              32'h80000000, 32'h00000000, 32'hBFA00000, 32'h80000000};
    run_op(1'b1, 7'd3, 0, 0, 0);

    // Leaky expd=127: exponent at/below expd flushes to -0
    rf    = '{32'hBF800000, 32'hC0000000, 32'h40000000, 32'hFF800000,
              32'hC2000000, 32'h807FFFFF, 32'hBF000000, 32'h7F7FFFFF};
    exp_v = '{32'h80000000, 32'h80800000, 32'h40000000, 32'hFF800000,
              32'h82800000, 32'h80000000, 32'h80000000, 32'h7F7FFFFF};
    run_op(1'b1, 7'd127, 0, 0, 0);

    // Leaky expd=0: identity except denormal/zero flush
    rf    = '{32'hC0490FDB, 32'h80000000, 32'hBF800000, 32'h3F800000,
              32'h00000001, 32'h80000001, 32'hFFC00000, 32'hC1200000};
    exp_v = '{32'hC0490FDB, 32'h80000000, 32'hBF800000, 32'h3F800000,
              32'h00000001, 32'h80000000, 32'hFFC00000, 32'hC1200000};
    run_op(1'b1, 7'd0, 0, 0, 0);

    // Start pulse while busy is ignored; then immediate restart
    gen_random(1'b1, 7'd3);
    run_op(1'b1, 7'd3, 5, 0, 0);
    gen_random(1'b0, 7'd0);
    run_op(1'b0, 7'd0, 0, 0, 0);

    // Mode/expd change mid-operation has no effect
    gen_random(1'b1, 7'd3);
    run_op(1'b1, 7'd3, 0, 4, 0);

    // Reset in cycle 5, then quiet, then a full pass
    gen_random(1'b1, 7'd5);
    run_op(1'b1, 7'd5, 0, 0, 5);
    bus.i_start = 1'b0;
    repeat (2) @(negedge clk);
    #2 nrst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_quiet", 64'({bus.o_busy, bus.o_rf_rd_en, bus.o_rf_wr_en}), 64'(0));
    end
    gen_random(1'b1, 7'd2);
    run_op(1'b1, 7'd2, 0, 0, 0);

    // Randomized passes
    for (int k = 0; k < 8; k++) begin
      logic       lk;
      logic [6:0] ex;
      lk = 1'($urandom_range(0, 1));
      ex = 7'($urandom_range(0, 127));
      gen_random(lk, ex);
      run_op(lk, ex, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
